// File: rtl/sel_toggle.sv
// -----------------------------------------------------------------------------
// sel_toggle
//
// Debounced push-button select controller for the downstream 2:1 mux stage.
// The raw button is passed through a two-flop synchronizer and then debounced.
// Each accepted press toggles the registered select `s`. Releases never toggle.
//
// Optional feature, controlled by the macro SEL_AUTO_EN:
//   When defined, an `auto` input and an auto timer are added. While `auto` is
//   high, `s` toggles every AUTO_PERIOD clocks. A debounced press always wins
//   over a simultaneous timer wrap, and a press restarts the timer.
//
// Parameters:
//   DB_CYCLES   - consecutive stable synchronized samples needed to accept a
//                 level change (>= 2)
//   CNT_W       - debounce counter width, 2**CNT_W > DB_CYCLES
//   AUTO_PERIOD - auto toggle period in clocks (>= 2), SEL_AUTO_EN only
//   AUTO_W      - auto timer width, 2**AUTO_W > AUTO_PERIOD, SEL_AUTO_EN only
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   btn     in   raw button, asynchronous to clk, may bounce
//   auto    in   auto-alternate enable (SEL_AUTO_EN only)
//   s       out  registered mux select (0 selects a, 1 selects b)
//   s_pulse out  one-cycle pulse coincident with each change of s
//   btn_db  out  registered debounced button level
//
// Handshake: none. All outputs are plain registered levels/pulses; s_pulse is
// valid for exactly the one cycle in which s holds its new value.
// -----------------------------------------------------------------------------
module sel_toggle #(
    parameter int DB_CYCLES   = 1000000,
    parameter int CNT_W       = 20
`ifdef SEL_AUTO_EN
    ,
    parameter int AUTO_PERIOD = 50000000,
    parameter int AUTO_W      = 26
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
`ifdef SEL_AUTO_EN
    input  logic auto,
`endif
    output logic s,
    output logic s_pulse,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // State is always consistent with (btn_db, cnt != 0); it is kept as its
    // own register so checkers can observe it by name.
    typedef enum logic [1:0] {
        REL       = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ff1;
    logic             btn_sync;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             btn_db_next;
    logic             press;
    logic             toggle;

`ifdef SEL_AUTO_EN
    localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_PERIOD - 1);
    localparam logic [AUTO_W-1:0] AUTO_ONE = AUTO_W'(1);

    logic [AUTO_W-1:0] timer;
    logic [AUTO_W-1:0] timer_next;
`endif

    // Debounce state machine: next state, counter and debounced level.
    always_comb begin
        state_next  = state;
        cnt_next    = '0;
        btn_db_next = btn_db;
        press       = 1'b0;
        case (state)
            REL: begin
                if (btn_sync) begin
                    cnt_next   = CNT_ONE;
                    state_next = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_next = REL;
                end else if (cnt == CNT_MAX) begin
                    btn_db_next = 1'b1;
                    state_next  = HELD;
                    press       = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    cnt_next   = CNT_ONE;
                    state_next = REL_CHK;
                end
            end
            REL_CHK: begin
                if (btn_sync) begin
                    state_next = HELD;
                end else if (cnt == CNT_MAX) begin
                    btn_db_next = 1'b0;
                    state_next  = REL;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next  = REL;
                btn_db_next = 1'b0;
            end
        endcase
    end

    // Select toggle request. A press takes priority over the auto timer so a
    // coincident press and wrap produce a single toggle.
    always_comb begin
        toggle = press;
`ifdef SEL_AUTO_EN
        timer_next = '0;
        if (!press && auto) begin
            if (timer == AUTO_MAX) begin
                toggle = 1'b1;
            end else begin
                timer_next = timer + AUTO_ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1      <= 1'b0;
            btn_sync <= 1'b0;
            state    <= REL;
            cnt      <= '0;
            btn_db   <= 1'b0;
            s        <= 1'b0;
            s_pulse  <= 1'b0;
`ifdef SEL_AUTO_EN
            timer    <= '0;
`endif
        end else begin
            ff1      <= btn;
            btn_sync <= ff1;
            state    <= state_next;
            cnt      <= cnt_next;
            btn_db   <= btn_db_next;
            s        <= s ^ toggle;
            s_pulse  <= toggle;
`ifdef SEL_AUTO_EN
            timer    <= timer_next;
`endif
        end
    end

endmodule

// File: tb/tb_sel_toggle.sv
// -----------------------------------------------------------------------------
// tb_sel_toggle
//
// Self-checking bench for sel_toggle with DB_CYCLES=4 (and AUTO_PERIOD=10 when
// SEL_AUTO_EN is defined). Directed per-edge checks compare s, s_pulse and
// btn_db against timing derived from the press/release latency (a change
// accepted 6 edges after the button level is first sampled). Every expected
// toggle also pushes the expected new s value into exp_q; a negedge monitor
// pops it whenever the DUT raises s_pulse.
// -----------------------------------------------------------------------------
module tb_sel_toggle;

    logic clk;
    logic rst;
    logic btn;
`ifdef SEL_AUTO_EN
    logic auto;
`endif
    logic s;
    logic s_pulse;
    logic btn_db;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   pulse_cnt = 0;
    logic [31:0] exp_q[$];

    sel_toggle #(
        .DB_CYCLES  (4),
        .CNT_W      (3)
`ifdef SEL_AUTO_EN
        ,
        .AUTO_PERIOD(10),
        .AUTO_W     (4)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
`ifdef SEL_AUTO_EN
        .auto   (auto),
`endif
        .s      (s),
        .s_pulse(s_pulse),
        .btn_db (btn_db)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: each pulse must match the next expected select value.
    always @(negedge clk) begin
        if (s_pulse === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("sb_unexpected_pulse", 32'd1, 32'd0);
            else check("sb_s", {31'd0, s}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn = 1'b0;
`ifdef SEL_AUTO_EN
        auto = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic edge_check(input string tag, input logic es, input logic ep);
        tick();
        check({tag, "_s"}, {31'd0, s}, {31'd0, es});
        check({tag, "_pulse"}, {31'd0, s_pulse}, {31'd0, ep});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] pat;
        int p0;

        rst = 1'b1;
        btn = 1'b1;
`ifdef SEL_AUTO_EN
        auto = 1'b0;
`endif
        // Reset held with the button pressed: outputs stay low.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_s", {31'd0, s}, 32'd0);
            check("rst_btn_db", {31'd0, btn_db}, 32'd0);
            check("rst_pulse", {31'd0, s_pulse}, 32'd0);
        end
        rst = 1'b0;
        // Still-held button is a new press: toggle 6 edges after release.
        exp_q.push_back(32'd1);
        for (int k = 1; k <= 8; k++) edge_check("rst_rel", k >= 6, k == 6);

        // Clean press held 20 cycles, then release.
        do_reset();
        btn = 1'b1;
        exp_q.push_back(32'd1);
        for (int k = 1; k <= 20; k++) begin
            edge_check("press", k >= 6, k == 6);
            if (k == 5 || k == 6) check("press_btn_db", {31'd0, btn_db}, (k == 6) ? 32'd1 : 32'd0);
        end
        btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            edge_check("release", 1'b1, 1'b0);
            check("release_btn_db", {31'd0, btn_db}, (k < 6) ? 32'd1 : 32'd0);
        end

        // Bounce 1,0,1,1,0 then held: final rise sampled at edge 6, toggle at 11.
        do_reset();
        pat = 5'b01101;
        exp_q.push_back(32'd1);
        for (int k = 1; k <= 14; k++) begin
            btn = (k <= 5) ? pat[k-1] : 1'b1;
            edge_check("bounce", k >= 11, k == 11);
        end
        btn = 1'b0;
        for (int k = 1; k <= 8; k++) tick();

        // Three clean press/release pairs: s goes 1, 0, 1.
        do_reset();
        p0 = pulse_cnt;
        for (int r = 0; r < 3; r++) begin
            logic e;
            e = (r % 2 == 0);
            exp_q.push_back({31'd0, e});
            btn = 1'b1;
            for (int k = 1; k <= 10; k++) edge_check("rep", (k >= 6) ? e : ~e, k == 6);
            btn = 1'b0;
            for (int k = 1; k <= 10; k++) edge_check("rep_rel", e, 1'b0);
        end
        check("rep_pulses", pulse_cnt - p0, 32'd3);
        check("rep_final_s", {31'd0, s}, 32'd1);

        // Reset asserted at cnt = 2, then the button is released: no toggle.
        do_reset();
        btn = 1'b1;
        for (int k = 1; k <= 4; k++) edge_check("midrst_pre", 1'b0, 1'b0);
        rst = 1'b1;
        edge_check("midrst_in", 1'b0, 1'b0);
        rst = 1'b0;
        btn = 1'b0;
        for (int k = 1; k <= 10; k++) edge_check("midrst_post", 1'b0, 1'b0);
        check("midrst_btn_db", {31'd0, btn_db}, 32'd0);

`ifdef SEL_AUTO_EN
        // Auto mode for 35 cycles: toggles at 10, 20, 30.
        do_reset();
        auto = 1'b1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        for (int k = 1; k <= 35; k++) edge_check("auto", ((k / 10) % 2) == 1, (k % 10) == 0);
        auto = 1'b0;
        for (int k = 1; k <= 12; k++) edge_check("auto_off", 1'b1, 1'b0);

        // Press accepted on the wrap edge (edge 10): one toggle, next at 20.
        do_reset();
        auto = 1'b1;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        for (int k = 1; k <= 22; k++) begin
            if (k == 5) btn = 1'b1;
            edge_check("wrap_press", (k >= 10) && (k < 20), (k == 10) || (k == 20));
        end
        auto = 1'b0;
        btn = 1'b0;
        for (int k = 1; k <= 10; k++) edge_check("wrap_rel", 1'b0, 1'b0);
`endif

        tick();
        check("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sel_toggle.md
# sel_toggle

Debounced push-button select controller that drives the select input `s` of the downstream 2:1 mux stage. A raw, asynchronous button is synchronized and debounced; each debounced press toggles the select level. It also exposes a one-cycle toggle pulse and the debounced button level. An optional compile-time auto-alternate mode toggles the select periodically without a button press.

## Interface
- `DB_CYCLES`, 1000000, number of consecutive stable synchronized samples required to accept a level change; must be ≥ 2
- `CNT_W`, 20, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES
- `AUTO_PERIOD`, 50000000, auto-toggle period in clocks; only present with `SEL_AUTO_EN`; must be ≥ 2
- `AUTO_W`, 26, auto timer width; must satisfy 2^AUTO_W > AUTO_PERIOD; only present with `SEL_AUTO_EN`

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `btn`  in  1  raw button, asynchronous to `clk`, may bounce
- `auto`  in  1  auto-alternate enable; port exists only with `SEL_AUTO_EN`
- `s`  out  1  registered mux select (0 selects `a`, 1 selects `b`)
- `s_pulse`  out  1  high for exactly one cycle on the edge where `s` changes
- `btn_db`  out  1  registered debounced button level

## Operation
- Synchronizer: two flops, `btn` → `ff1` → `btn_sync`. Both reset to 0. No other logic reads `btn` directly.
- Debounce counter `cnt` (CNT_W bits):
  - cleared whenever `btn_sync == btn_db`;
  - otherwise incremented while `cnt < DB_CYCLES-1`;
  - when `cnt == DB_CYCLES-1` and the levels still differ, the next edge flips `btn_db` and clears `cnt`.
- State machine, decoded from `btn_db` and `cnt`:
  - REL: `btn_db = 0`, `cnt = 0`.
  - PRESS_CHK: `btn_db = 0`, `cnt ≠ 0`. Goes to HELD on acceptance, or back to REL if `btn_sync` returns to 0.
  - HELD: `btn_db = 1`, `cnt = 0`.
  - REL_CHK: `btn_db = 1`, `cnt ≠ 0`. Goes to REL on acceptance, or back to HELD if `btn_sync` returns to 1.
- Select toggling:
  - Only the PRESS_CHK → HELD transition toggles `s` and asserts `s_pulse`.
  - Release never toggles `s`.
  - Holding the button produces exactly one toggle.
- Any glitch shorter than DB_CYCLES synchronized cycles returns to the previous stable state with `cnt = 0`. `s` does not change.
- Reset values: `s = 0`, `s_pulse = 0`, `btn_db = 0`, `cnt = 0`, `ff1 = btn_sync = 0`, auto timer = 0.
- Reset asserted mid-debounce or mid-hold returns the block to REL with all of the above values. A button still held after reset deassertion is treated as a new press: after the full debounce latency, `s` toggles once.

## Timing
- Press latency: with `btn` held high from the edge that first samples it (edge 1):
  - `btn_sync = 1` after edge 2;
  - `cnt = j` after edge 2+j;
  - `btn_db`, `s` and `s_pulse` update at edge 2+DB_CYCLES.
- Release latency is identical: `btn_db` falls at edge 2+DB_CYCLES, with no effect on `s`.
- `s_pulse` is high for exactly one cycle and is coincident with the new `s` value.
- `btn_db` falls DB_CYCLES synchronized cycles after release begins. The earliest next accepted press therefore follows DB_CYCLES cycles later again; the maximum toggle rate is one per 2·DB_CYCLES cycles.

## Configuration
- Macro: `SEL_AUTO_EN`.
- Defined:
  - Adds the `auto` port, the `AUTO_PERIOD` and `AUTO_W` parameters, and an auto timer.
  - While `auto = 1`, the timer counts 0..AUTO_PERIOD-1. On the edge where it wraps from AUTO_PERIOD-1 to 0, `s` toggles and `s_pulse` asserts.
  - While `auto = 0`, the timer is held at 0.
  - A debounced press toggles `s` and clears the timer on the same edge.
  - If a press acceptance and a timer wrap land on the same edge, the press wins: `s` toggles once, not twice, and the timer clears.
- Undefined: no `auto` port, no timer, no auto parameters. `s` changes only on debounced presses.

## Test plan
Bench parameters: DB_CYCLES=4, AUTO_PERIOD=10.
- Reset: hold `rst` for 3 cycles with `btn = 1` → `s = 0`, `btn_db = 0`, `s_pulse = 0` throughout. After release of `rst`, `s` goes to 1 exactly 6 edges later.
- Clean press: `btn` rises and is held for 20 cycles → `s` goes 0→1 at edge 6, with a single `s_pulse`. `btn` then falls → `btn_db` falls 6 edges later and `s` stays 1.
- Bounce: `btn` pattern 1,0,1,1,0 in cycles 1–5, then 1 held → no toggle from the bounce. `s` toggles exactly once, 4 stable `btn_sync` cycles after the final rise.
- Repeated presses: 3 clean press/release pairs, each held 10 cycles → `s` sequence 1,0,1 and exactly 3 `s_pulse` pulses.
- Mid-debounce reset: press, assert `rst` at `cnt = 2` for 1 cycle, then release `btn` → `s = 0`, no pulse.
- `SEL_AUTO_EN` build: `auto = 1` for 35 cycles → `s` toggles at cycles 10, 20, 30. A press accepted on a timer-wrap edge → single toggle, and the next auto toggle occurs 10 cycles later.
